add_serial_param: RTL and testbench

//   Parametrised digit-serial adder/subtractor; successor to the fixed 8-bit bit-serial adder.

---
 rtl/add_serial_param.sv | 128 ++++++++++++
 tb/tb_add_serial_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_serial_param.sv
// rtl/add_serial_param.sv - digit-serial add/subtract, LSB-first, with carry-out and signed overflow
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("add_serial_param: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_sa;
    logic             r_sb;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_count;

    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_out_shift;
    logic             w_accept;
    logic             w_last;

    // Subtraction is a + ~b + 1 with the borrow-in folded into that +1.
    assign w_b_in   = sub ? ~b : b;
    assign w_sum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_count == LAST);

    generate
        if (STEPS == 1) begin : g_single_step
            assign w_out_shift = w_sum[DIGIT-1:0];
        end else begin : g_multi_step
            assign w_out_shift = {w_sum[DIGIT-1:0], r_out[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ADD;
            S_ADD:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  if (w_accept) w_state_next = S_ADD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_out   <= '0;
            r_carry <= cin ^ sub;
            r_sa    <= a[WIDTH-1];
            r_sb    <= w_b_in[WIDTH-1];
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (r_state == S_ADD) begin
            r_out   <= w_out_shift;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_sum[DIGIT];
            r_count <= r_count + CW'(1);
            // The final digit holds the result sign bit and the true carry out of the MSB.
            if (w_last) begin
                r_cout <= w_sum[DIGIT];
                r_ovf  <= (r_sa == r_sb) && (w_sum[DIGIT-1] != r_sa);
            end
        end
    end

    assign out  = r_out;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = (r_state == S_ADD);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_add_serial_param.sv
// tb/tb_add_serial_param.sv - bench for add_serial_param (digit widths 1 and 4)
module tb_add_serial_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1;
    logic       start4;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;

    logic [7:0] o1, o4;
    logic       c1, c4, v1, v4, busy1, busy4, done1, done4;

    logic       sel;
    logic [7:0] m_out;
    logic       m_cout, m_ovf, m_busy, m_done;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc;

    always #5 clk = ~clk;

    add_serial_param #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .cin(cin), .a(a), .b(b),
        .out(o1), .cout(c1), .ovf(v1), .busy(busy1), .done(done1)
    );

    add_serial_param #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .cin(cin), .a(a), .b(b),
        .out(o4), .cout(c4), .ovf(v4), .busy(busy4), .done(done4)
    );

    assign m_out  = sel ? o4    : o1;
    assign m_cout = sel ? c4    : c1;
    assign m_ovf  = sel ? v4    : v1;
    assign m_busy = sel ? busy4 : busy1;
    assign m_done = sel ? done4 : done1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic void model(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                                  input logic c, output logic [7:0] eo, output logic ec,
                                  output logic ev);
        int u;
        int sg;
        if (!s) begin
            u  = int'(aa) + int'(bb) + int'(c);
            sg = int'($signed(aa)) + int'($signed(bb)) + int'(c);
            ec = (u > 255);
        end else begin
            u  = int'(aa) - int'(bb) - int'(c);
            sg = int'($signed(aa)) - int'($signed(bb)) - int'(c);
            ec = (u >= 0);
        end
        eo = u[7:0];
        ev = (sg > 127) || (sg < -128);
    endfunction

    task automatic run(input logic which, input logic [7:0] aa, input logic [7:0] bb,
                       input logic s, input logic c, input string tag);
        logic [7:0] eo;
        logic       ec;
        logic       ev;
        int         steps;
        model(aa, bb, s, c, eo, ec, ev);
        steps = which ? 2 : 8;
        sel = which;
        @(negedge clk);
        a = aa; b = bb; sub = s; cin = c;
        if (which) start4 = 1'b1;
        else       start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        chk({tag, ".busy_after_start"}, 32'(m_busy), 32'd1);
        chk({tag, ".done_after_start"}, 32'(m_done), 32'd0);
        cyc = 0;
        while (m_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 32'(cyc), 32'(steps));
        chk({tag, ".done"}, 32'(m_done), 32'd1);
        chk({tag, ".out"},  32'(m_out),  32'(eo));
        chk({tag, ".cout"}, 32'(m_cout), 32'(ec));
        chk({tag, ".ovf"},  32'(m_ovf),  32'(ev));
    endtask

    initial begin
        logic [7:0] held_out;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; sub = 1'b0; cin = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.out1",  32'(o1),    32'd0);
        chk("reset.cout1", 32'(c1),    32'd0);
        chk("reset.ovf1",  32'(v1),    32'd0);
        chk("reset.busy1", 32'(busy1), 32'd0);
        chk("reset.done1", 32'(done1), 32'd0);
        chk("reset.busy4", 32'(busy4), 32'd0);
        chk("reset.done4", 32'(done4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy1", 32'(busy1), 32'd0);

        run(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
        chk("add_5a_3c.const_out", 32'(o1), 32'h96);
        chk("add_5a_3c.const_ovf", 32'(v1), 32'd1);
        run(1'b0, 8'h10, 8'h20, 1'b1, 1'b0, "sub_10_20");
        chk("sub_10_20.const_out", 32'(o1), 32'hF0);
        run(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        run(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "add_cin");
        run(1'b0, 8'h55, 8'h22, 1'b1, 1'b1, "sub_borrow_in");
        run(1'b0, 8'h00, 8'h80, 1'b1, 1'b0, "sub_neg_min");
        run(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, "d4_add_7f_01");
        chk("d4_add_7f_01.const_out", 32'(o4), 32'h80);
        run(1'b1, 8'h80, 8'h01, 1'b1, 1'b0, "d4_sub_80_01");

        // Start held high during ADD must not disturb the operation in flight.
        sel = 1'b0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy1) cyc++;
            @(negedge clk);
        end
        start1 = 1'b0;
        while (busy1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("held_start.busy_cycles", 32'(cyc),   32'd8);
        chk("held_start.done",        32'(done1), 32'd1);
        chk("held_start.out",         32'(o1),    32'h46);

        held_out = o1;
        repeat (5) @(negedge clk);
        chk("done_hold.out",  32'(o1),    32'(held_out));
        chk("done_hold.done", 32'(done1), 32'd1);

        run(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, "back_to_back");
        chk("back_to_back.const_out", 32'(o1), 32'h03);

        // Reset in the middle of an operation abandons it.
        sel = 1'b0;
        @(negedge clk);
        a = 8'h77; b = 8'h11; sub = 1'b0; cin = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst.busy", 32'(busy1), 32'd0);
        chk("mid_rst.done", 32'(done1), 32'd0);
        chk("mid_rst.out",  32'(o1),    32'd0);
        chk("mid_rst.cout", 32'(c1),    32'd0);
        @(negedge clk);
        chk("mid_rst.still_idle", 32'(done1), 32'd0);
        run(1'b0, 8'h77, 8'h11, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            run(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
